// File: rtl/word_split.sv
// word_split: splits an NB-byte word into a stream of NB 8-bit beats, LSB first.
// A new word can be accepted on the final beat handshake, so back-to-back words
// stream without bubbles.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   data_in   input word, byte k = data_in[8k+7:8k]
//   valid_a   upstream word valid
//   ready_a   word can be accepted this cycle (combinational)
//   data_out  current byte (registered)
//   valid_b   data_out valid (registered)
//   ready_b   downstream accepts the byte this cycle
//   last_b    final beat of the word (registered)
//   sum_b     sum of all bytes of the word, nonzero only with last_b (registered)
module word_split #(
    parameter int unsigned NB = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [8*NB-1:0] data_in,
    input  logic            valid_a,
    output logic            ready_a,
    output logic [7:0]      data_out,
    output logic            valid_b,
    input  logic            ready_b,
    output logic            last_b,
    output logic [9:0]      sum_b
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;
    localparam logic [1:0] LAST_IDX = 2'(NB - 1);

    logic [0:0]      r_state;
    logic [8*NB-1:0] r_word;
    logic [1:0]      r_cnt;
    logic [9:0]      r_wsum;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_last;
    logic [9:0]      r_sum_out;

    logic            w_ready_a;
    logic            w_load;
    logic            w_beat;
    logic [1:0]      w_cnt_nxt;
    logic [7:0]      w_next_byte;
    logic [9:0]      w_sum;

    // In SEND a word may only be taken as the final byte leaves.
    assign w_ready_a = (r_state == ST_IDLE) || ((r_cnt == LAST_IDX) && ready_b);
    assign w_load    = valid_a && w_ready_a;
    assign w_beat    = r_valid && ready_b;
    assign w_cnt_nxt = r_cnt + 2'd1;

    always_comb begin
        w_next_byte = '0;
        for (int k = 0; k < NB; k++) begin
            if (w_cnt_nxt == 2'(k)) begin
                w_next_byte = r_word[8*k +: 8];
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NB; k++) begin
            w_sum = w_sum + 10'(data_in[8*k +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_word    <= '0;
            r_cnt     <= '0;
            r_wsum    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_sum_out <= '0;
        end else if (w_load) begin
            // Byte 0 goes straight to the output register; NB >= 2 so it is never last.
            r_state   <= ST_SEND;
            r_word    <= data_in;
            r_cnt     <= '0;
            r_wsum    <= w_sum;
            r_data    <= data_in[7:0];
            r_valid   <= 1'b1;
            r_last    <= 1'b0;
            r_sum_out <= '0;
        end else if (w_beat) begin
            if (r_cnt == LAST_IDX) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_valid   <= 1'b0;
                r_last    <= 1'b0;
                r_sum_out <= '0;
            end else begin
                r_cnt     <= w_cnt_nxt;
                r_data    <= w_next_byte;
                r_last    <= (w_cnt_nxt == LAST_IDX);
                r_sum_out <= (w_cnt_nxt == LAST_IDX) ? r_wsum : '0;
            end
        end
    end

    assign ready_a  = w_ready_a;
    assign data_out = r_data;
    assign valid_b  = r_valid;
    assign last_b   = r_last;
    assign sum_b    = r_sum_out;

endmodule

// File: doc/word_split.md
WORD_SPLIT -- requirements
Module: word_split

Interface
REQ-001 Parameter NB, default 4, number of 8-bit beats per input word; legal range 2..4.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data_in  input  8*NB  word to split; byte k = data_in[8k+7:8k].
REQ-005 valid_a  input  1  upstream word valid.
REQ-006 ready_a  output  1  block can accept a word this cycle; combinational from state and ready_b.
REQ-007 data_out  output  8  current byte, registered.
REQ-008 valid_b  output  1  data_out valid, registered.
REQ-009 ready_b  input  1  downstream accepts the byte this cycle.
REQ-010 last_b  output  1  high on the final beat of a word, registered.
REQ-011 sum_b  output  10  sum of all NB bytes of the word; meaningful only when last_b=1, registered.

Function
REQ-012 Word handshake SHALL occur on a rising edge with valid_a=1 and ready_a=1; beat handshake SHALL occur on a rising edge with valid_b=1 and ready_b=1.
REQ-013 FSM SHALL have two states: IDLE and SEND.
REQ-014 IDLE: valid_b=0, last_b=0, ready_a=1; a word handshake SHALL load the word and a beat counter of 0, then go to SEND.
REQ-015 In SEND, bytes SHALL be emitted LSB first (byte 0, byte 1, ... byte NB-1), one per beat handshake.
REQ-016 Latency: byte 0 SHALL be valid on the cycle after the word handshake.
REQ-017 In SEND, ready_a SHALL be 1 only when the current beat is byte NB-1 and ready_b=1; otherwise 0.
REQ-018 On the final beat handshake with valid_a=1, the new word SHALL load and its byte 0 SHALL appear the next cycle with no bubble, remaining in SEND.
REQ-019 On the final beat handshake with valid_a=0, the FSM SHALL return to IDLE and valid_b SHALL fall the next cycle.
REQ-020 Stall: while valid_b=1 and ready_b=0, data_out, last_b, sum_b, valid_b and the beat counter SHALL hold.
REQ-021 last_b SHALL be 1 exactly when byte NB-1 is presented; otherwise 0.
REQ-022 sum_b SHALL equal the unsigned, zero-extended sum of the NB bytes, computed at word load; it cannot overflow (max 1020).
REQ-023 sum_b SHALL be 0 when last_b=0.
REQ-024 data_in and valid_a SHALL be ignored when ready_a=0.
REQ-025 Bytes above NB-1 do not exist; for NB<4 the port is 8*NB wide and no other bits are consumed.
REQ-026 Sustained throughput SHALL be one byte per cycle when valid_a=1 and ready_b=1 throughout.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, beat counter 0, data_out=0, valid_b=0, last_b=0, sum_b=0.
REQ-028 While rst_n is low, ready_a SHALL read 1 (IDLE), but no word handshake SHALL be taken.
REQ-029 Reset during SEND SHALL discard the partial word with no further beats.
REQ-030 After release, the next word SHALL start at byte 0.

Verification
REQ-031 NB=4, word 0x04030201, ready_b=1 -> data_out 01,02,03,04 on 4 consecutive cycles; last_b=1 only on 04; sum_b=0x00A on that beat.
REQ-032 Word 0xFFFFFFFF -> four beats of 0xFF; final beat sum_b=0x3FC.
REQ-033 Words 0x11223344 then 0xAABBCCDD with valid_a held and ready_b=1 -> 8 beats with no gap (44,33,22,11,DD,CC,BB,AA); sum_b 0x0AA then 0x30E; ready_a=1 only on cycles where byte 3 is presented.
REQ-034 ready_b=0 for 3 cycles while byte 1 (0x02 of 0x04030201) is presented -> data_out holds 0x02, valid_b=1, ready_a=0; sequence resumes 03,04 once ready_b=1.
REQ-035 rst_n pulsed low after beat 1 of 0x04030201 -> valid_b=0 immediately; after release, word 0x08070605 emits 05,06,07,08 with sum_b=0x01A.
REQ-036 NB=2, word 0xFF01 -> two beats 01,FF; last_b on FF; sum_b=0x100.
